// File: rtl/mm_host_sequencer_pkg.sv
// Shared types and constants for the matrix-multiply host sequencer.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_WAIT_DONE,
        ST_DRAIN,
        ST_CLEAR
    } state_e;

    localparam int N_ELEM = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 8;

endpackage

// File: rtl/mm_host_sequencer_if.sv
// Host byte streams plus the controller load/read/reset bus.
interface mm_host_sequencer_if;
    import mm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_byte;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_byte;
    logic              busy;
    logic              err;
    logic              load_en;
    logic              load_sel_ab;
    logic [IDX_W-1:0]  load_index;
    logic [DATA_W-1:0] load_data;
    logic              mm_done;
    logic              output_en;
    logic [IDX_W-1:0]  output_sel;
    logic [DATA_W-1:0] rd_data;
    logic              ctrl_rst;

    modport master (
        input  in_valid, in_byte, out_ready, mm_done, rd_data,
        output in_ready, out_valid, out_byte, busy, err,
        output load_en, load_sel_ab, load_index, load_data,
        output output_en, output_sel, ctrl_rst
    );

    modport slave (
        output in_valid, in_byte, out_ready, mm_done, rd_data,
        input  in_ready, out_valid, out_byte, busy, err,
        input  load_en, load_sel_ab, load_index, load_data,
        input  output_en, output_sel, ctrl_rst
    );

endinterface

// File: rtl/mm_host_sequencer.sv
// Streams A/B bytes into the 2x2 multiply controller, waits for done,
// drains the four result bytes and pulses the controller reset per job.
module mm_host_sequencer
    import mm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ARM_CYCLES     = 2
) (
    input logic                 clk,
    input logic                 rst,
    mm_host_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_ARM  = WAIT_W'(ARM_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  OUT_LAST  = IDX_W'(N_ELEM - 1);

    state_e            state_q, state_d;
    logic [2:0]        load_cnt_q, load_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]  out_cnt_q, out_cnt_d;
    logic              err_q, err_d;

    logic in_ready;
    logic out_valid;
    logic in_hs;
    logic out_hs;
    logic done_qual;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN);
    assign in_hs     = bus.in_valid & in_ready;
    assign out_hs    = out_valid & bus.out_ready;
    // Early done is masked: it may be left over from the previous job.
    assign done_qual = bus.mm_done & (wait_cnt_q >= WAIT_ARM);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        wait_cnt_d = wait_cnt_q;
        out_cnt_d  = out_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_hs) begin
                    if (load_cnt_q == 3'd7) begin
                        load_cnt_d = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT_DONE;
                    end else begin
                        load_cnt_d = load_cnt_q + 3'd1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (done_qual) begin
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    err_d      = 1'b1;
                    state_d    = ST_CLEAR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        state_d   = ST_CLEAR;
                    end else begin
                        out_cnt_d = out_cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            load_cnt_q <= '0;
            wait_cnt_q <= '0;
            out_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            out_cnt_q  <= out_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.load_en     = in_hs & ~rst;
    assign bus.load_sel_ab = load_cnt_q[2];
    assign bus.load_index  = load_cnt_q[1:0];
    assign bus.load_data   = bus.in_byte;

    assign bus.out_valid   = out_valid;
    assign bus.output_en   = out_valid;
    assign bus.output_sel  = out_cnt_q;
    assign bus.out_byte    = out_valid ? bus.rd_data : '0;

    assign bus.busy        = ~((state_q == ST_LOAD) && (load_cnt_q == 3'd0));
    assign bus.err         = err_q;
    assign bus.ctrl_rst    = rst | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Directed bench: controller stub, job-level reference model, per-cycle compare.
module tb_mm_host_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mm_host_sequencer_if bus ();

    mm_host_sequencer #(
        .TIMEOUT_CYCLES(64),
        .ARM_CYCLES    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Controller stub: dmode 0 done once loaded, 1 done 3 cycles later, 2 never.
    // rmode 0 returns the true 2x2 product, 1 returns 0xA0+index.
    int         dmode = 0;
    int         rmode = 0;
    logic [7:0] ma [4];
    logic [7:0] mb [4];
    int         cl    = 0;
    int         since = 0;

    always @(posedge clk) begin
        if (bus.ctrl_rst) begin
            cl    <= 0;
            since <= 0;
        end else begin
            if (bus.load_en) begin
                if (bus.load_sel_ab) mb[bus.load_index] <= bus.load_data;
                else                 ma[bus.load_index] <= bus.load_data;
                cl <= cl + 1;
            end
            if (cl == 8) since <= since + 1;
        end
    end

    always_comb begin
        bus.mm_done = 1'b0;
        if (dmode == 0) bus.mm_done = (cl == 8);
        if (dmode == 1) bus.mm_done = (cl == 8) && (since >= 3);
    end

    always_comb begin
        int i;
        int j;
        int s;
        i = int'(bus.output_sel[1]);
        j = int'(bus.output_sel[0]);
        s = int'(ma[2*i]) * int'(mb[j]) + int'(ma[2*i+1]) * int'(mb[2+j]);
        bus.rd_data = (rmode == 0) ? s[7:0] : (8'hA0 + {6'd0, bus.output_sel});
    end

    // Reference model: job phase 0 load, 1 wait, 2 drain, 3 clear.
    int ph = 0;
    int n  = 0;
    int w  = 0;
    int o  = 0;
    int em = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; n = 0; w = 0; o = 0; em = 0;
        end else begin
            case (ph)
                0: if (bus.in_valid) begin
                    n = n + 1;
                    if (n == 8) begin n = 0; w = 0; ph = 1; end
                end
                1: begin
                    if (bus.mm_done && w >= 2) begin ph = 2; w = 0; end
                    else if (w + 1 == 64) begin ph = 3; w = 0; em = 1; end
                    else w = w + 1;
                end
                2: if (bus.out_ready) begin
                    o = o + 1;
                    if (o == 4) begin o = 0; ph = 3; end
                end
                default: ph = 0;
            endcase
        end
    end

    logic [7:0]  expq [$];
    logic [10:0] ldlog [$];
    int          hs_out = 0;
    int          cr_cnt = 0;
    int          wc_cnt = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [7:0]  pb = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", bus.in_ready, ph == 0);
            chk("out_valid", bus.out_valid, ph == 2);
            chk("output_en", bus.output_en, ph == 2);
            chk("ctrl_rst", bus.ctrl_rst, ph == 3);
            chk("busy", bus.busy, !(ph == 0 && n == 0));
            chk("err", bus.err, em);
            chk("load_en", bus.load_en, ph == 0 && bus.in_valid);
            if (ph == 0 && bus.in_valid) begin
                chk("load_sel_ab", bus.load_sel_ab, n / 4);
                chk("load_index", bus.load_index, n % 4);
                chk("load_data", bus.load_data, bus.in_byte);
            end
            if (ph == 2) begin
                chk("output_sel", bus.output_sel, o);
                chk("out_byte_pass", bus.out_byte, bus.rd_data);
            end
            if (pv && !pr && bus.out_valid)
                chk("out_byte_hold", bus.out_byte, pb);
            if (bus.load_en)
                ldlog.push_back({bus.load_sel_ab, bus.load_index, bus.load_data});
            if (bus.out_valid && bus.out_ready) begin
                hs_out++;
                if (expq.size() == 0) chk("out_unexpected", bus.out_byte, -1);
                else chk("out_stream", bus.out_byte, expq.pop_front());
            end
            if (bus.ctrl_rst) cr_cnt++;
            if (bus.busy && !bus.in_ready && !bus.out_valid && !bus.ctrl_rst)
                wc_cnt++;
            pv = bus.out_valid;
            pr = bus.out_ready;
            pb = bus.out_byte;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] base, input int cnt, input bit toggle);
        for (int k = 0; k < cnt; k++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = base + 8'(k);
            tick();
            if (toggle) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_job_end();
        int b;
        b = 0;
        while (!bus.ctrl_rst && b < 400) begin
            tick();
            b++;
        end
        chk("job_end_in_time", b < 400, 1);
        tick();
    endtask

    task automatic push_stub();
        expq.push_back(8'hA0);
        expq.push_back(8'hA1);
        expq.push_back(8'hA2);
        expq.push_back(8'hA3);
    endtask

    int s_hs;
    int s_cr;
    int s_wc;

    task automatic snap();
        s_hs = hs_out;
        s_cr = cr_cnt;
        s_wc = wc_cnt;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_load_en", bus.load_en, 0);
        chk("rst_output_en", bus.output_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ctrl_rst", bus.ctrl_rst, 1);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();

        // Real product: [1 2;3 4] x [5 6;7 8]
        dmode = 0; rmode = 0;
        expq.push_back(8'd19);
        expq.push_back(8'd22);
        expq.push_back(8'd43);
        expq.push_back(8'd50);
        snap();
        send(8'd1, 8, 1'b0);
        wait_job_end();
        chk("j1_out_hs", hs_out - s_hs, 4);
        chk("j1_ctrl_rst_pulses", cr_cnt - s_cr, 1);
        chk("j1_wait_cycles", wc_cnt - s_wc, 3);
        chk("j1_err", bus.err, 0);

        // Input backpressure
        dmode = 1; rmode = 1;
        push_stub();
        ldlog.delete();
        send(8'h10, 8, 1'b1);
        wait_job_end();
        chk("bp_load_count", ldlog.size(), 8);
        for (int k = 0; k < 8 && k < ldlog.size(); k++)
            chk("bp_load_entry", ldlog[k],
                {k >= 4 ? 1'b1 : 1'b0, 2'(k % 4), 8'h10 + 8'(k)});

        // Output backpressure on byte 1
        push_stub();
        snap();
        bus.out_ready = 1'b0;
        send(8'h20, 8, 1'b0);
        begin
            int b;
            b = 0;
            while (!bus.out_valid && b < 100) begin tick(); b++; end
            chk("ob_out_valid_seen", bus.out_valid, 1);
        end
        chk("ob_wait_cycles", wc_cnt - s_wc, 4);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("ob_stall_byte", bus.out_byte, 8'hA1);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_job_end();
        chk("ob_out_hs", hs_out - s_hs, 4);

        // Stale done held from entry
        dmode = 0; rmode = 1;
        push_stub();
        snap();
        send(8'h30, 8, 1'b0);
        wait_job_end();
        chk("stale_wait_cycles", wc_cnt - s_wc, 3);

        // Timeout
        dmode = 2;
        snap();
        send(8'h40, 8, 1'b0);
        wait_job_end();
        chk("to_wait_cycles", wc_cnt - s_wc, 64);
        chk("to_out_hs", hs_out - s_hs, 0);
        chk("to_ctrl_rst_pulses", cr_cnt - s_cr, 1);
        chk("to_err", bus.err, 1);

        dmode = 1;
        push_stub();
        snap();
        send(8'h50, 8, 1'b0);
        wait_job_end();
        chk("post_to_out_hs", hs_out - s_hs, 4);
        chk("post_to_err_sticky", bus.err, 1);

        // Reset mid-job, then [2 3;4 5] x [6 7;8 9]
        dmode = 0; rmode = 0;
        send(8'h60, 5, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ctrl_rst", bus.ctrl_rst, 1);
        chk("mid_rst_err_clr", bus.err, 0);
        tick();
        rst = 1'b0;
        tick();
        expq.push_back(8'd36);
        expq.push_back(8'd41);
        expq.push_back(8'd64);
        expq.push_back(8'd73);
        snap();
        ldlog.delete();
        send(8'd2, 8, 1'b0);
        wait_job_end();
        chk("mr_first_load", ldlog.size() > 0 ? int'(ldlog[0]) : -1,
            int'({1'b0, 2'd0, 8'd2}));
        chk("mr_out_hs", hs_out - s_hs, 4);

        tick();
        chk("exp_queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
